// File: rtl/mem_stage_lsu.sv
// RV64 memory-access stage: one outstanding req/gnt/rvalid access, store lane alignment, load extract/extend.
// Latency: load 3, store 2 stall cycles (zero-wait memory), +1 per gnt/rvalid wait; stall_mem freezes upstream until DONE.
module mem_stage_lsu #(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            valid_mem,
   input  logic            memread_mem,
   input  logic            memwrite_mem,
   input  logic [2:0]      funct3_mem,
   input  logic [XLEN-1:0] aluresult_mem,
   input  logic [XLEN-1:0] storedata_mem,
   input  logic [4:0]      dst_mem,
   input  logic            memtoreg_mem,
   input  logic            regwrite_mem,
   output logic            dmem_req,
   output logic            dmem_we,
   output logic [XLEN-1:0] dmem_addr,
   output logic [XLEN-1:0] dmem_wdata,
   output logic [7:0]      dmem_wstrb,
   input  logic            dmem_gnt,
   input  logic            dmem_rvalid,
   input  logic [XLEN-1:0] dmem_rdata,
   output logic            stall_mem,
   output logic            mem_exc,
   output logic            memtoreg_out,
   output logic            regwrite_out,
   output logic [4:0]      dst_out,
   output logic [XLEN-1:0] dmemrd_out,
   output logic [XLEN-1:0] aluresult_out
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   state_t          state;
   logic [XLEN-1:0] ld_data;
   logic            memop;
   logic            is_load;
   logic            illegal;
   logic            misaligned;
   logic            bad;
   logic [2:0]      off;
   logic [5:0]      sh;
   logic [7:0]      strb;
   logic [XLEN-1:0] lane;
   logic [XLEN-1:0] ld_ext;

   assign memop   = valid_mem & (memread_mem | memwrite_mem);
   assign is_load = memread_mem;
   assign off     = aluresult_mem[2:0];
   assign sh      = {off, 3'b000};
   assign lane    = dmem_rdata >> sh;

   // A slot flagged both read and write is treated as a load.
   always_comb begin
      illegal    = is_load ? (funct3_mem == 3'b111) : funct3_mem[2];
      misaligned = 1'b0;
      case (funct3_mem[1:0])
         2'b01:   misaligned = off[0];
         2'b10:   misaligned = (off[1:0] != 2'b00);
         2'b11:   misaligned = (off != 3'b000);
         default: misaligned = 1'b0;
      endcase
   end

   assign bad = memop & (misaligned | illegal);

   always_comb begin
      strb = 8'hFF;
      case (funct3_mem[1:0])
         2'b00:   strb = 8'h01 << off;
         2'b01:   strb = 8'h03 << off;
         2'b10:   strb = 8'h0F << off;
         default: strb = 8'hFF;
      endcase
   end

   always_comb begin
      ld_ext = lane;
      case (funct3_mem)
         3'b000:  ld_ext = {{(XLEN-8){lane[7]}}, lane[7:0]};
         3'b001:  ld_ext = {{(XLEN-16){lane[15]}}, lane[15:0]};
         3'b010:  ld_ext = {{(XLEN-32){lane[31]}}, lane[31:0]};
         3'b100:  ld_ext = {{(XLEN-8){1'b0}}, lane[7:0]};
         3'b101:  ld_ext = {{(XLEN-16){1'b0}}, lane[15:0]};
         3'b110:  ld_ext = {{(XLEN-32){1'b0}}, lane[31:0]};
         default: ld_ext = lane;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         dmem_addr  <= '0;
         dmem_wdata <= '0;
         dmem_wstrb <= 8'h00;
         ld_data    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (memop && !bad) begin
                  dmem_req   <= 1'b1;
                  dmem_we    <= !is_load;
                  dmem_addr  <= {aluresult_mem[XLEN-1:3], 3'b000};
                  dmem_wdata <= is_load ? '0 : (storedata_mem << sh);
                  dmem_wstrb <= is_load ? 8'h00 : strb;
                  state      <= REQ;
               end
            end
            REQ: begin
               if (dmem_gnt) begin
                  dmem_req <= 1'b0;
                  state    <= dmem_we ? DONE : WAIT;
               end
            end
            WAIT: begin
               if (dmem_rvalid) begin
                  ld_data <= ld_ext;
                  state   <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign stall_mem     = memop & !bad & (state != DONE);
   assign mem_exc       = bad;
   assign aluresult_out = aluresult_mem;
   assign dst_out       = dst_mem;
   assign memtoreg_out  = memtoreg_mem & valid_mem;
   assign dmemrd_out    = ld_data;
   // Memory ops only write back in DONE, so MEM/WB sees a bubble on every stall cycle.
   assign regwrite_out  = regwrite_mem & valid_mem & !bad & (!memop | (state == DONE));

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Memory-access stage of the RV64 scalar pipeline, between the EX/MEM register and the MEM/WB register.
- Runs loads and stores against the data memory through a req/gnt/rvalid handshake.
- Aligns store data and generates byte strobes; extracts and sign/zero-extends load data.
- Stalls the pipeline while an access is in flight and presents completed results to MEM/WB.

Parameters:
XLEN, 64, data/address width
(exactly one parameter; XLEN=64 only)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
valid_mem  in  1  EX/MEM slot holds a live instruction
memread_mem  in  1  load
memwrite_mem  in  1  store
funct3_mem  in  3  access size/sign
aluresult_mem  in  64  effective address or ALU result
storedata_mem  in  64  rs2 value for stores
dst_mem  in  5  destination register
memtoreg_mem  in  1  writeback selects load data
regwrite_mem  in  1  writeback enable
dmem_req  out  1  memory request (registered)
dmem_we  out  1  1=write (registered)
dmem_addr  out  64  doubleword-aligned address, addr[2:0]=0 (registered)
dmem_wdata  out  64  lane-shifted store data (registered)
dmem_wstrb  out  8  byte enables (registered)
dmem_gnt  in  1  request accepted
dmem_rvalid  in  1  read data valid
dmem_rdata  in  64  read doubleword
stall_mem  out  1  freeze PC/IF/ID/EX and EX/MEM
mem_exc  out  1  misaligned or illegal access
memtoreg_out  out  1  to MEM/WB memtoreg_mem
regwrite_out  out  1  to MEM/WB regwrite_mem
dst_out  out  5  to MEM/WB dst_mem
dmemrd_out  out  64  to MEM/WB dmemrd_mem
aluresult_out  out  64  to MEM/WB aluresult_mem

Behaviour:
- memop = valid_mem & (memread_mem | memwrite_mem).
- off = aluresult_mem[2:0].
- Loads, funct3:
  - 000 LB; 001 LH; 010 LW; 011 LD; 100 LBU; 101 LHU; 110 LWU.
  - 111 is illegal.
- Stores, funct3:
  - 000 SB; 001 SH; 010 SW; 011 SD.
  - 1xx is illegal.
- Misaligned when: H with off[0]≠0; W with off[1:0]≠0; D with off≠0.
- bad = memop & (misaligned | illegal).
- mem_exc = bad (combinational). A bad access issues no request, does not stall, and forces regwrite_out=0.
- Store lanes:
  - wdata = storedata_mem << 8*off.
  - wstrb: SB 8'h01<<off; SH 8'h03<<off; SW 8'h0F<<off; SD 8'hFF.
  - Load requests drive wstrb=0.
- Load extract: lane = dmem_rdata >> 8*off, truncated to the access size, then sign-extended (LB/LH/LW) or zero-extended (LBU/LHU/LWU). LD is the full doubleword.
- FSM states: IDLE, REQ, WAIT, DONE.
  - IDLE: on memop & !bad, register the dmem_* outputs, set dmem_req=1 → REQ.
  - REQ: hold all dmem_* outputs stable until dmem_gnt. On gnt, drop dmem_req next cycle. Store → DONE; load → WAIT.
  - WAIT: on dmem_rvalid, capture the extracted value into ld_data → DONE.
  - DONE: one cycle → IDLE.
- Handshake rules:
  - dmem_rvalid is never asserted in the same cycle as dmem_gnt.
  - dmem_rvalid outside WAIT is ignored.
  - Exactly one outstanding access.
- stall_mem = memop & !bad & (state≠DONE), combinational.
- Non-memory or invalid slot: stall_mem=0, state stays IDLE.
- Outputs to MEM/WB, all combinational:
  - aluresult_out = aluresult_mem.
  - dst_out = dst_mem.
  - memtoreg_out = memtoreg_mem & valid_mem.
  - dmemrd_out = ld_data.
  - regwrite_out = regwrite_mem & valid_mem & !bad & (!memop | state==DONE). MEM/WB therefore captures a bubble on every stall cycle.
- Latency (zero-wait memory):
  - Load: stall 3 cycles (IDLE, REQ with gnt, WAIT with rvalid); result presented in DONE.
  - Store: stall 2 cycles.
  - Each extra gnt or rvalid wait cycle adds one stall cycle.
- Back-to-back memory ops: after DONE the next instruction enters EX/MEM and starts from IDLE. No bypass.
- Reset values: state=IDLE, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, dmem_wstrb=0, ld_data=0.
  - Combinational outputs follow from the reset state and current inputs.
- Reset mid-operation aborts the transaction. Any later gnt/rvalid is ignored in IDLE.

Test Plan:
- LW, addr 0x1004, zero-wait memory, rdata 0x80000000_11223344 → dmem_addr 0x1000, wstrb 0; stall_mem high 3 cycles; in DONE dmemrd_out 0xFFFFFFFF_80000000, regwrite_out 1.
- LBU, addr 0x2007, rdata 0xAB00..00 → dmemrd_out 0x00000000_000000AB. Same access as LB → 0xFFFFFFFF_FFFFFFAB.
- SH, addr 0x3002, storedata 0xBEEF → dmem_wdata 0x00000000_BEEF0000, wstrb 8'h0C, dmem_we 1; gnt delayed 2 cycles → stall 4 cycles, regwrite_out 0.
- LD, addr 0x4004 → mem_exc 1, dmem_req never rises, stall_mem 0, regwrite_out 0.
- Reset asserted in WAIT, then rvalid pulses → state IDLE, ld_data 0, no DONE, stall_mem follows the post-reset inputs.
- ADD result 0x55, regwrite 1, no memop → stall_mem 0, regwrite_out 1, aluresult_out 0x55, dmem_req stays 0.
